fsm_receptor: RTL

Receiving end of the processor's `send`/`ack`/`dado` handshake. It accepts each 16-bit word the processor presents with `send = 2'b01`, acknowledges it with `ack = 2'b01`, and queues the word in a small FIFO. A downstream consumer drains the FIFO through a valid/ready port. The block sits between the processor FSM and the consuming datapath, and its job is to keep the processor from stalling while the FIFO has space.

---
 rtl/fsm_receptor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fsm_receptor.sv
// Receiver side of the send/ack/dado four-phase handshake, queuing words
// into a small FIFO drained through a valid/ready port. Optional macro: FSM_RECEPTOR_BUSY_EN.
module fsm_receptor #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 send,
  input  logic [DATA_W-1:0]          dado,
  output logic [1:0]                 ack,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_OK   = 2'b01;
`ifdef FSM_RECEPTOR_BUSY_EN
  localparam logic [1:0] ACK_WAIT = 2'b10;
`else
  localparam logic [1:0] ACK_WAIT = 2'b00;
`endif

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    FULL_WAIT,
    ACK
  } state_t;

  state_t state, state_next;
  logic [1:0] ack_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  logic req;
  logic rsvd;
  logic has_space;
  logic wr;
  logic pop;

  // Reserved codes behave like idle apart from flagging the error.
  assign req       = (send == 2'b01);
  assign rsvd      = send[1];
  assign has_space = (cnt < CW'(DEPTH));
  assign pop       = (cnt != '0) && out_ready;

  assign out_valid = (cnt != '0);
  assign out_data  = mem[rd_ptr];
  assign count     = cnt;

  // Next-state, FIFO write request and next ack code.
  always_comb begin
    state_next = state;
    wr         = 1'b0;
    unique case (state)
      SYNC: begin
        if (!req) state_next = IDLE;
      end
      IDLE: begin
        if (req && has_space) begin
          wr         = 1'b1;
          state_next = ACK;
        end else if (req) begin
          state_next = FULL_WAIT;
        end
      end
      FULL_WAIT: begin
        if (!req) begin
          state_next = IDLE;
        end else if (has_space) begin
          wr         = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!req) state_next = IDLE;
      end
      default: state_next = SYNC;
    endcase
    unique case (state_next)
      ACK:       ack_next = ACK_OK;
      FULL_WAIT: ack_next = ACK_WAIT;
      default:   ack_next = ACK_NONE;
    endcase
  end

  // State, registered ack and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      ack       <= ACK_NONE;
      proto_err <= 1'b0;
    end else begin
      state <= state_next;
      ack   <= ack_next;
      if (rsvd) proto_err <= 1'b1;
    end
  end

  // Pointers and occupancy; full check above uses pre-pop occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= dado;
  end

endmodule
